csa_stream_accumulator: RTL
===========================

// Module: csa_stream_accumulator
// PURPOSE
//  Sequential multi-operand adder: accepts a stream of WIDTH-bit unsigned operands, one per cycle,
//  and keeps the running total in carry-save form (sum/carry vectors, one 3:2 CSA level per beat).
//  On group end, one carry-propagate add resolves the total, which is presented on a valid/ready port.
//  Generalises the fixed 9 x 16-bit carry-save adder to arbitrary width, group length and streaming input.
// PARAMETERS
//  WIDTH     16   operand width in bits
//  MAX_OPS   9    maximum operands per group (>=2); reaching it forces group end
//  OUT_WIDTH WIDTH+$clog2(MAX_OPS+1) (localparam, 20 at defaults): result width, never overflows
//  CNT_W     $clog2(MAX_OPS+1) (localparam): operand counter width
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          operand valid
//  in_ready   out  1          accumulator can take an operand this cycle
//  in_data    in   WIDTH      unsigned operand
//  in_last    in   1          operand is last of its group
//  out_valid  out  1          result valid, held until accepted
//  out_ready  in   1          downstream accepts result
//  out_sum    out  OUT_WIDTH  resolved group total
//  out_count  out  CNT_W      number of operands in the group (1..MAX_OPS)
//  out_forced out  1          group ended by reaching MAX_OPS without in_last
// BEHAVIOUR
//  Reset: state=ACC; S=C=0; count=0; out_valid=0; out_sum=0; out_count=0; out_forced=0.
//   Reset takes priority over every other event, including mid-group and with out_valid high
//   (the pending result is dropped). in_valid is ignored while rst=1.
//  FSM states: ACC, RESOLVE, OUT. in_ready = (state==ACC), combinational from state only.
//  ACC: beat accepted when in_valid && in_ready. Per beat: S <= S ^ C ^ x; C <= maj(S,C,x) << 1;
//   x = in_data zero-extended to OUT_WIDTH; all vectors truncated to OUT_WIDTH bits; count <= count+1.
//   Go to RESOLVE if (in_last) or (count+1 == MAX_OPS); latch forced = !in_last on that beat.
//   No beat: all state held; gaps of any length allowed.
//  RESOLVE (1 cycle, in_ready=0): out_sum <= S + C (OUT_WIDTH bits), out_count <= count,
//   out_forced <= forced, out_valid <= 1; go to OUT.
//  OUT: out_* held stable while out_ready=0. On out_valid && out_ready: out_valid <= 0,
//   S=C=0, count=0, return to ACC (in_ready high the following cycle).
//  Latency: last beat accepted in cycle t -> out_valid high in cycle t+2. Throughput: a group of N
//   operands occupies N+2 cycles when out_ready=1 (no overlap of accumulation and output).
//  Boundaries: group of 1 (in_last on first beat) valid, out_count=1. Beat after a forced group end
//   starts a new group. in_last on the MAX_OPS-th beat: out_forced=0. Never an empty group.
//  Width rule: MAX_OPS*(2^WIDTH-1) < 2^OUT_WIDTH, so out_sum is exact; no overflow flag.
// TESTING
//  T1 9 beats 0xFFFF, in_last on 9th -> out_sum=0x8FFF7 (589815), out_count=9, out_forced=0,
//     out_valid 2 cycles after the 9th beat.
//  T2 single beat 0x0001 with in_last -> out_sum=1, out_count=1; then 3 and 11 (last) -> 14, count=2.
//  T3 10 beats of 0x0001, in_last only on 10th -> first result 9, count=9, forced=1;
//     second result 1, count=1, forced=0.
//  T4 hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_sum/out_count stable,
//     no beat consumed; release -> next group starts the cycle after the handshake.
//  T5 4 beats of 0x1234 then rst for 1 cycle -> out_valid=0, in_ready=1 after reset;
//     new group 0x0005,0x0007 (last) -> out_sum=12, out_count=2.
//  T6 beats 0x8000,0x8000,0xFFFF(last) with 1-3 idle cycles between -> out_sum=0x1FFFF, count=3.

Source files
------------

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
// Streaming multi-operand adder. Operands are folded into a carry-save
// running total (one 3:2 compressor level per accepted beat). When the group
// ends, a single carry-propagate add resolves the total. The result is then
// held on a valid/ready output port until it is accepted.
module csa_stream_accumulator #(
  parameter  int WIDTH     = 16,
  parameter  int MAX_OPS   = 9,
  localparam int CNT_W     = $clog2(MAX_OPS + 1),
  localparam int OUT_WIDTH = WIDTH + CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_forced
);

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  state_t               state_reg;
  logic [OUT_WIDTH-1:0] sum_reg;
  logic [OUT_WIDTH-1:0] carry_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 forced_reg;

  logic [OUT_WIDTH-1:0] operand;
  logic [OUT_WIDTH-1:0] sum_next;
  logic [OUT_WIDTH-1:0] carry_next;
  logic [CNT_W-1:0]     count_next;
  logic                 beat;
  logic                 group_end;

  // The operand is zero-extended so the compressor works at full result width.
  assign operand    = {{CNT_W{1'b0}}, in_data};
  assign in_ready   = (state_reg == ACC);
  assign beat       = in_valid && in_ready;
  assign count_next = count_reg + 1'b1;
  // A group closes on in_last, or when this beat fills the last operand slot.
  assign group_end  = in_last || (count_next == MAX_CNT);

  // One 3:2 compressor level. The majority vector is shifted up one bit.
  // The top majority bit falls off, which the width rule makes harmless.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_csa
      assign sum_next[gi] = sum_reg[gi] ^ carry_reg[gi] ^ operand[gi];
      if (gi == 0) begin : g_lsb
        assign carry_next[gi] = 1'b0;
      end else begin : g_bit
        assign carry_next[gi] = (sum_reg[gi-1] & carry_reg[gi-1]) |
                                (sum_reg[gi-1] & operand[gi-1])   |
                                (carry_reg[gi-1] & operand[gi-1]);
      end
    end
  endgenerate

  // Control FSM together with the accumulator state and the registered result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ACC;
      sum_reg    <= '0;
      carry_reg  <= '0;
      count_reg  <= '0;
      forced_reg <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_forced <= 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (beat) begin
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            count_reg <= count_next;
            if (group_end) begin
              forced_reg <= !in_last;
              state_reg  <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          out_sum    <= sum_reg + carry_reg;
          out_count  <= count_reg;
          out_forced <= forced_reg;
          out_valid  <= 1'b1;
          state_reg  <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum_reg   <= '0;
            carry_reg <= '0;
            count_reg <= '0;
            state_reg <= ACC;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

endmodule
